dm_access_unit: RTL and testbench
=================================

DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum cycles from acceptance to completion before a bus fault.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 m_valid  in  1  SHALL flag a new instruction presented by the EX/DM pipeline register.
REQ-005 m_alu_y  in  32  SHALL carry the byte address.
REQ-006 m_wdata  in  32  SHALL carry the unaligned store data (rs2).
REQ-007 m_mem_re / m_mem_we  in  1 each  SHALL flag load / store, taken from the stage control bundle.
REQ-008 m_funct3  in  3  SHALL select access size and sign.
REQ-009 dmem_req, dmem_we  out  1; dmem_addr  out  32; dmem_be  out  4; dmem_wdata  out  32  SHALL form the memory request.
REQ-010 dmem_gnt, dmem_rvalid  in  1; dmem_rdata  in  32  SHALL form the memory response.
REQ-011 stall  out  1  SHALL freeze the upstream pipeline.
REQ-012 done  out  1; load_data  out  32  SHALL signal completion and give extended load data.
REQ-013 fault_misaligned, fault_bus  out  1  SHALL be one-cycle fault pulses.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT_RD.
REQ-015 Access SHALL be accepted in IDLE when m_valid & exactly one of re/we & legal funct3 & aligned.
REQ-016 Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW; any other code SHALL raise fault_misaligned.
REQ-017 Misalignment: half with addr[0]=1, word with addr[1:0]!=0; SHALL pulse fault_misaligned in the same cycle, issue no request, and keep stall low.
REQ-018 re and we both high SHALL be handled as REQ-017: fault, no request.
REQ-019 On acceptance, the block SHALL register dmem_addr={addr[31:2],2'b00}, be, wdata, we, and funct3/addr[1:0], then enter REQ; outputs SHALL be stable until gnt.
REQ-020 Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; load be SHALL equal its size pattern.
REQ-021 Store wdata: SB {4{b}}, SH {2{h}}, SW unchanged.
REQ-022 REQ: dmem_req=1; on gnt a store SHALL go to IDLE with done=1 that cycle; a load SHALL go to WAIT_RD.
REQ-023 WAIT_RD: on dmem_rvalid, load_data SHALL be the selected byte/half shifted down by addr[1:0] and sign- or zero-extended per funct3, with done=1 that cycle, then IDLE.
REQ-024 stall SHALL be high in IDLE on acceptance, in REQ and in WAIT_RD, except low in the completion cycle (done=1).
REQ-025 load_data SHALL be valid only while done=1 and SHALL be 0 otherwise.
REQ-026 Timeout counter SHALL clear on acceptance and increment each cycle in REQ/WAIT_RD; reaching TIMEOUT_CYCLES SHALL pulse fault_bus, drop stall, return to IDLE, and leave done low.
REQ-027 rvalid outside WAIT_RD and gnt outside REQ SHALL be ignored.
REQ-028 Back-to-back accesses SHALL be accepted in the IDLE cycle directly after done.

Reset
REQ-029 Asserting reset at any time, including mid-access, SHALL force IDLE, clear the counter and drive every output to 0 with no further request.

Structure
REQ-030 A shared package SHALL hold the funct3 encodings and the dm_state_t enum.
REQ-031 Alignment and extension logic SHALL be a combinational sub-module dm_load_extend.
REQ-032 Target size: 150-300 lines of RTL.

Verification
REQ-033 SW addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> be=1111, wdata 0xDEADBEEF, stall 3 cycles then done.
REQ-034 LB addr 0x103, rdata 0x80xxxxxx -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH addr 0x102, data 0x1234 -> be=1100, wdata 0x12341234.
REQ-036 LW addr 0x101 -> fault_misaligned 1 cycle, dmem_req never high, stall 0.
REQ-037 LW with no gnt, TIMEOUT_CYCLES=16 -> fault_bus at cycle 16, done never high, FSM IDLE.
REQ-038 reset low during WAIT_RD -> dmem_req, stall, done 0 immediately; a late rvalid is ignored.

Source files
------------

// File: rtl/dm_access_unit_pkg.sv
// Shared encodings for the data-memory access stage.
// funct3 load/store size codes and the access FSM state type.
package dm_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } dm_state_t;

endpackage

// File: rtl/dm_load_extend.sv
// Size/alignment decode, store lane replication and
// load lane extraction with sign/zero extension.
module dm_load_extend
  import dm_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] st_raw,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  logic [31:0] sh;

  // Request side: legality, alignment, lanes, store data.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    be      = 4'b0000;
    st_data = st_raw;
    case (funct3)
      F3_B, F3_BU: begin
        legal   = !is_store || (funct3 == F3_B);
        aligned = 1'b1;
        be      = 4'b0001 << addr_lo;
        st_data = {4{st_raw[7:0]}};
      end
      F3_H, F3_HU: begin
        legal   = !is_store || (funct3 == F3_H);
        aligned = !addr_lo[0];
        be      = 4'b0011 << addr_lo;
        st_data = {2{st_raw[15:0]}};
      end
      F3_W: begin
        legal   = 1'b1;
        aligned = (addr_lo == 2'b00);
        be      = 4'b1111;
      end
      default: ;
    endcase
  end

  // Response side: shift the addressed lane down, then extend.
  always_comb begin
    sh = rdata >> {ld_addr_lo, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   ld_data = {24'h0, sh[7:0]};
      F3_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   ld_data = {16'h0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access stage: one outstanding load/store,
// pipeline stall while busy, misalign and bus-timeout faults.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_alu_y,
  input  logic [31:0] m_wdata,
  input  logic        m_mem_re,
  input  logic        m_mem_we,
  input  logic [2:0]  m_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault_misaligned,
  output logic        fault_bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  dm_state_t   state, state_nx;
  logic [CW-1:0] cnt;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;

  logic        legal, aligned;
  logic [3:0]  be_c;
  logic [31:0] st_c, ld_c;
  logic        is_mem, one_op, accept, timeout;

  dm_load_extend u_ext (
    .funct3     (m_funct3),
    .addr_lo    (m_alu_y[1:0]),
    .is_store   (m_mem_we),
    .st_raw     (m_wdata),
    .ld_funct3  (f3_q),
    .ld_addr_lo (lo_q),
    .rdata      (dmem_rdata),
    .legal      (legal),
    .aligned    (aligned),
    .be         (be_c),
    .st_data    (st_c),
    .ld_data    (ld_c)
  );

  // Reset gates the inputs so outputs read zero while held.
  assign is_mem  = reset & m_valid & (m_mem_re | m_mem_we);
  assign one_op  = m_mem_re ^ m_mem_we;
  assign accept  = (state == IDLE) & is_mem & one_op
                 & legal & aligned;
  assign timeout = (cnt >= CNT_LAST);

  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? {addr_q, 2'b00} : '0;
  assign dmem_be    = dmem_req ? be_q : '0;
  assign dmem_wdata = dmem_req ? wdata_q : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Capture the request on acceptance; held until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      lo_q    <= '0;
    end else if (accept) begin
      addr_q  <= m_alu_y[31:2];
      be_q    <= be_c;
      wdata_q <= m_mem_we ? st_c : '0;
      we_q    <= m_mem_we;
      f3_q    <= m_funct3;
      lo_q    <= m_alu_y[1:0];
    end
  end

  // Cycles spent waiting on the bus since acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (accept)         cnt <= '0;
    else if (state != IDLE)  cnt <= cnt + 1'b1;
  end

  // Next state, handshake, stall and fault pulses.
  always_comb begin
    state_nx         = state;
    dmem_req         = 1'b0;
    done             = 1'b0;
    stall            = 1'b0;
    load_data        = '0;
    fault_misaligned = 1'b0;
    fault_bus        = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          state_nx = REQ;
        end else if (is_mem) begin
          fault_misaligned = 1'b1;
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          if (we_q) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else begin
            stall    = 1'b1;
            state_nx = WAIT_RD;
          end
        end else if (timeout) begin
          fault_bus = 1'b1;
          state_nx  = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid) begin
          done      = 1'b1;
          load_data = ld_c;
          state_nx  = IDLE;
        end else if (timeout) begin
          fault_bus = 1'b1;
          state_nx  = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: stores, loads,
// faults, timeout and mid-access reset.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_alu_y;
  logic [31:0] m_wdata;
  logic        m_mem_re;
  logic        m_mem_we;
  logic [2:0]  m_funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        fault_misaligned;
  logic        fault_bus;

  int n_checks = 0;
  int n_fail   = 0;

  dm_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .m_valid          (m_valid),
    .m_alu_y          (m_alu_y),
    .m_wdata          (m_wdata),
    .m_mem_re         (m_mem_re),
    .m_mem_we         (m_mem_we),
    .m_funct3         (m_funct3),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_be          (dmem_be),
    .dmem_wdata       (dmem_wdata),
    .dmem_gnt         (dmem_gnt),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .stall            (stall),
    .done             (done),
    .load_data        (load_data),
    .fault_misaligned (fault_misaligned),
    .fault_bus        (fault_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    m_valid     = 1'b0;
    m_mem_re    = 1'b0;
    m_mem_we    = 1'b0;
    m_alu_y     = '0;
    m_wdata     = '0;
    m_funct3    = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
  endtask

  task automatic issue(input logic re, input logic we,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d);
    m_valid  = 1'b1;
    m_mem_re = re;
    m_mem_we = we;
    m_funct3 = f3;
    m_alu_y  = a;
    m_wdata  = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    quiet();
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({dmem_req, dmem_we, stall, done,
         fault_misaligned, fault_bus} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req/we/stall/done/fm/fb=%b expected 000000",
        {dmem_req, dmem_we, stall, done, fault_misaligned, fault_bus});
    end
    n_checks++;
    if (dmem_addr !== 32'h0 || dmem_be !== 4'h0 ||
        dmem_wdata !== 32'h0 || load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h be=%b wdata=%h ld=%h expected all 0",
        dmem_addr, dmem_be, dmem_wdata, load_data);
    end
    tick();
    quiet();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_sw();
    int stalls;
    stalls = 0;
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_accept: stall=%b req=%b expected stall=1 req=0",
        stall, dmem_req);
    end
    if (stall === 1'b1) stalls++;
    tick();
    quiet();
    for (int i = 0; i < 3; i++) begin
      dmem_gnt = (i == 2);
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      if (i == 0) begin
        n_checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 ||
            dmem_addr !== 32'h100 || dmem_be !== 4'b1111 ||
            dmem_wdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL sw_req: req=%b we=%b addr=%h be=%b wd=%h expected 1 1 00000100 1111 deadbeef",
            dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (done !== 1'b1 || stall !== 1'b0) begin
          n_fail++;
          $display("FAIL sw_done: done=%b stall=%b expected done=1 stall=0",
            done, stall);
        end
      end
      tick();
      quiet();
    end
    n_checks++;
    if (stalls != 3) begin
      n_fail++;
      $display("FAIL sw_stall_cycles: got %0d expected 3", stalls);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80000000;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1 || done !== 1'b0 || load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b_accept: stall=%b done=%b ld=%h expected 1 0 0",
        stall, done, load_data);
    end
    tick();
    quiet();
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h11000000;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 ||
        dmem_addr !== 32'h100 || dmem_be !== 4'b1000 ||
        done !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL lb_req: req=%b we=%b addr=%h be=%b done=%b stall=%b expected 1 0 00000100 1000 0 1",
        dmem_req, dmem_we, dmem_addr, dmem_be, done, stall);
    end
    tick();
    quiet();
    dmem_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b1 || load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL lb_wait: req=%b stall=%b ld=%h expected 0 1 0",
        dmem_req, stall, load_data);
    end
    tick();
    quiet();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80123456;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || stall !== 1'b0 || load_data !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL lb_data: done=%b stall=%b ld=%h expected 1 0 ffffff80",
        done, stall, load_data);
    end
    tick();
    quiet();
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL lb_after: done=%b ld=%h expected 0 0", done, load_data);
    end
    tick();
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3;
    logic [31:0] a, rd, exp;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin f3 = 3'b100; a = 32'h103; rd = 32'h80ABCDEF; exp = 32'h00000080; end
        1: begin f3 = 3'b001; a = 32'h102; rd = 32'h8001CDEF; exp = 32'hFFFF8001; end
        2: begin f3 = 3'b101; a = 32'h102; rd = 32'h8001CDEF; exp = 32'h00008001; end
        3: begin f3 = 3'b000; a = 32'h101; rd = 32'h00008000; exp = 32'hFFFFFF80; end
        default: begin f3 = 3'b010; a = 32'h104; rd = 32'hCAFEF00D; exp = 32'hCAFEF00D; end
      endcase
      issue(1'b1, 1'b0, f3, a, 32'h0);
      @(negedge clk);
      tick();
      quiet();
      dmem_gnt = 1'b1;
      @(negedge clk);
      tick();
      quiet();
      dmem_rvalid = 1'b1;
      dmem_rdata  = rd;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || load_data !== exp) begin
        n_fail++;
        $display("FAIL load_ext[%0d]: done=%b ld=%h expected done=1 ld=%h",
          i, done, load_data, exp);
      end
      tick();
      quiet();
    end
  endtask

  task automatic test_sub_word_store();
    logic [2:0]  f3;
    logic [31:0] a, d, exp_wd;
    logic [3:0]  exp_be;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        f3 = 3'b001; a = 32'h102; d = 32'h00001234;
        exp_be = 4'b1100; exp_wd = 32'h12341234;
      end else begin
        f3 = 3'b000; a = 32'h101; d = 32'h000000AB;
        exp_be = 4'b0010; exp_wd = 32'hABABABAB;
      end
      issue(1'b0, 1'b1, f3, a, d);
      @(negedge clk);
      tick();
      quiet();
      dmem_gnt = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dmem_be !== exp_be || dmem_wdata !== exp_wd ||
          dmem_addr !== 32'h100 || dmem_we !== 1'b1 ||
          done !== 1'b1 || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL store[%0d]: be=%b wd=%h addr=%h we=%b done=%b stall=%b expected be=%b wd=%h 00000100 1 1 0",
          i, dmem_be, dmem_wdata, dmem_addr, dmem_we, done, stall,
          exp_be, exp_wd);
      end
      tick();
      quiet();
    end
  endtask

  task automatic test_misaligned();
    logic        re, we;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin re = 1; we = 0; f3 = 3'b010; a = 32'h101; end
        1: begin re = 1; we = 0; f3 = 3'b001; a = 32'h103; end
        2: begin re = 0; we = 1; f3 = 3'b010; a = 32'h102; end
        3: begin re = 1; we = 1; f3 = 3'b010; a = 32'h100; end
        4: begin re = 1; we = 0; f3 = 3'b011; a = 32'h100; end
        default: begin re = 0; we = 1; f3 = 3'b100; a = 32'h100; end
      endcase
      issue(re, we, f3, a, 32'h55);
      @(negedge clk);
      n_checks++;
      if (fault_misaligned !== 1'b1 || dmem_req !== 1'b0 ||
          stall !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign[%0d]: fm=%b req=%b stall=%b expected 1 0 0",
          i, fault_misaligned, dmem_req, stall);
      end
      tick();
      quiet();
      @(negedge clk);
      n_checks++;
      if (fault_misaligned !== 1'b0 || dmem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_after[%0d]: fm=%b req=%b expected 0 0",
          i, fault_misaligned, dmem_req);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int fb_at, fb_cnt, done_cnt, req_after;
    fb_at = 0; fb_cnt = 0; done_cnt = 0; req_after = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    @(negedge clk);
    tick();
    quiet();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (fault_bus === 1'b1) begin
        fb_cnt++;
        if (fb_at == 0) fb_at = c;
      end
      if (done !== 1'b0) done_cnt++;
      if (c > 16 && dmem_req !== 1'b0) req_after++;
      if (c == 16) begin
        n_checks++;
        if (stall !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_stall: stall=%b expected 0", stall);
        end
      end
      tick();
    end
    n_checks++;
    if (fb_at != 16 || fb_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_fault: first at %0d count %0d expected at 16 count 1",
        fb_at, fb_cnt);
    end
    n_checks++;
    if (done_cnt != 0 || req_after != 0) begin
      n_fail++;
      $display("FAIL timeout_idle: done cycles %0d req after %0d expected 0 0",
        done_cnt, req_after);
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    @(negedge clk);
    tick();
    quiet();
    dmem_gnt = 1'b1;
    @(negedge clk);
    tick();
    quiet();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pre: stall=%b req=%b expected 1 0", stall, dmem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_now: req=%b stall=%b done=%b expected 0 0 0",
        dmem_req, stall, done);
    end
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h00000055;
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0 ||
        load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_late_rvalid: done=%b stall=%b req=%b ld=%h expected 0 0 0 0",
        done, stall, dmem_req, load_data);
    end
    tick();
    quiet();
    issue(1'b0, 1'b1, 3'b000, 32'h010, 32'h7);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_recover: stall=%b expected 1", stall);
    end
    tick();
    quiet();
    dmem_gnt = 1'b1;
    @(negedge clk);
    tick();
    quiet();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_back_to_back();
    test_load_extend();
    test_sub_word_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
